// File: rtl/bcd_alu.sv
// bcd_alu: digit-serial sign-magnitude BCD adder/subtractor.
// Handles one start/done transaction at a time. It processes one BCD digit per
// clock, least significant digit first.
//   clock       in   system clock (rising edge)
//   reset       in   synchronous active-high reset
//   start       in   request, sampled only while idle
//   operation   in   3'b000 SUM, 3'b001 SUB, anything else is an error
//   operand0/1  in   packed-BCD magnitudes A and B (nibble 0 = LSD)
//   sign0/1     in   operand signs (1 = negative)
//   busy        out  high while the operation is in progress
//   done        out  one-cycle pulse when the result outputs are updated
//   result      out  packed-BCD result magnitude
//   result_sign out  result sign (never negative for a zero result)
//   overflow    out  carry out of the MSD on an effective add
//   error       out  unsupported operation code
module bcd_alu #(
    parameter int DIGIT_NUM = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0]             operation,
    input  logic [DIGIT_NUM*4-1:0] operand0,
    input  logic                   sign0,
    input  logic [DIGIT_NUM*4-1:0] operand1,
    input  logic                   sign1,
    output logic                   busy,
    output logic                   done,
    output logic [DIGIT_NUM*4-1:0] result,
    output logic                   result_sign,
    output logic                   overflow,
    output logic                   error
);

    localparam int W  = DIGIT_NUM * 4;
    localparam int IW = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGIT_NUM - 1);
    localparam logic [2:0] OP_SUM = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    logic            r_sign0;
    logic            r_sign1;
    logic            r_sub;
    logic            r_eff_sub;
    logic            r_rsign;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic            r_busy;
    logic            r_done;
    logic [W-1:0]    r_result;
    logic            r_result_sign;
    logic            r_overflow;
    logic            r_error;

    logic            w_op_ok;
    logic            w_sign_b;
    logic            w_diff_signs;
    logic            w_swap;
    logic [4:0]      w_sum;
    logic [4:0]      w_rhs;
    logic [4:0]      w_sub_wrap;
    logic [3:0]      w_digit;
    logic            w_cout;
    logic [W-1:0]    w_acc_next;

    assign w_op_ok      = (operation == OP_SUM) || (operation == OP_SUB);
    // Subtraction is addition of B with its sign flipped.
    assign w_sign_b     = r_sign1 ^ r_sub;
    assign w_diff_signs = r_sign0 ^ w_sign_b;
    // Packed BCD orders like unsigned binary, so a plain compare picks the larger magnitude.
    assign w_swap       = w_diff_signs && (r_b > r_a);
    assign w_acc_next   = {w_digit, r_acc[W-1:4]};

    // Next-state logic for the operation sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_op_ok) begin
                        w_next = S_PREP;
                    end else begin
                        w_next = S_DONE;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_PREP: w_next = S_CALC;
            S_CALC: begin
                if (r_idx == LAST_IDX) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_CALC;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // One-digit BCD add or subtract on the current low nibbles.
    always_comb begin
        w_sum      = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0000, r_carry};
        w_rhs      = {1'b0, r_b[3:0]} + {4'b0000, r_carry};
        w_sub_wrap = {1'b0, r_a[3:0]} + 5'd10 - w_rhs;
        w_digit    = 4'd0;
        w_cout     = 1'b0;
        if (r_eff_sub) begin
            if ({1'b0, r_a[3:0]} < w_rhs) begin
                w_digit = w_sub_wrap[3:0];
                w_cout  = 1'b1;
            end else begin
                w_digit = r_a[3:0] - w_rhs[3:0];
                w_cout  = 1'b0;
            end
        end else begin
            if (w_sum > 5'd9) begin
                w_digit = w_sum[3:0] + 4'd6;
                w_cout  = 1'b1;
            end else begin
                w_digit = w_sum[3:0];
                w_cout  = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Handshake outputs, registered from the upcoming state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == S_PREP) || (w_next == S_CALC);
            r_done <= (w_next == S_DONE);
        end
    end

    // Operand capture, digit-serial datapath and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a           <= '0;
            r_b           <= '0;
            r_acc         <= '0;
            r_sign0       <= 1'b0;
            r_sign1       <= 1'b0;
            r_sub         <= 1'b0;
            r_eff_sub     <= 1'b0;
            r_rsign       <= 1'b0;
            r_carry       <= 1'b0;
            r_idx         <= '0;
            r_result      <= '0;
            r_result_sign <= 1'b0;
            r_overflow    <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_op_ok) begin
                        r_a     <= operand0;
                        r_b     <= operand1;
                        r_sign0 <= sign0;
                        r_sign1 <= sign1;
                        r_sub   <= (operation == OP_SUB);
                    end else if (start) begin
                        r_result      <= '0;
                        r_result_sign <= 1'b0;
                        r_overflow    <= 1'b0;
                        r_error       <= 1'b1;
                    end
                end
                S_PREP: begin
                    if (w_swap) begin
                        r_a     <= r_b;
                        r_b     <= r_a;
                        r_rsign <= w_sign_b;
                    end else begin
                        r_rsign <= r_sign0;
                    end
                    r_eff_sub <= w_diff_signs;
                    r_carry   <= 1'b0;
                    r_idx     <= '0;
                end
                S_CALC: begin
                    r_a     <= {4'b0000, r_a[W-1:4]};
                    r_b     <= {4'b0000, r_b[W-1:4]};
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IW'(1);
                    if (r_idx == LAST_IDX) begin
                        r_result      <= w_acc_next;
                        // A zero magnitude is always reported as positive.
                        r_result_sign <= r_rsign && (w_acc_next != '0);
                        r_overflow    <= !r_eff_sub && w_cout;
                        r_error       <= 1'b0;
                    end
                end
                default: begin
                    r_carry <= r_carry;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign result_sign = r_result_sign;
    assign overflow    = r_overflow;
    assign error       = r_error;

endmodule

// File: tb/tb_bcd_alu.sv
// tb_bcd_alu: directed self-checking bench for bcd_alu with DIGIT_NUM = 8.
module tb_bcd_alu;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  operation;
    logic [31:0] operand0;
    logic        sign0;
    logic [31:0] operand1;
    logic        sign1;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        result_sign;
    logic        overflow;
    logic        error;

    int total;
    int bad;

    bcd_alu #(.DIGIT_NUM(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .operation   (operation),
        .operand0    (operand0),
        .sign0       (sign0),
        .operand1    (operand1),
        .sign1       (sign1),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_sign (result_sign),
        .overflow    (overflow),
        .error       (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Pulse start for one cycle, then wait (bounded) for done.
    // lat counts cycles from the start cycle to the done cycle.
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic sa,
                          input logic [31:0] b, input logic sb,
                          output int lat, output bit busy_seen, output bit busy_at_done);
        operation = op;
        operand0  = a;
        sign0     = sa;
        operand1  = b;
        sign1     = sb;
        start     = 1'b1;
        busy_seen = 1'b0;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            if (busy) busy_seen = 1'b1;
            tick();
            lat++;
        end
        busy_at_done = busy;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if ({result, result_sign, overflow, error} !== 35'd0) begin
            bad++; $display("FAIL reset_outputs got=%h/%b/%b/%b exp=0", result, result_sign, overflow, error);
        end
    endtask

    task automatic test_sum;
        int lat; bit bs; bit bd;
        launch(3'b000, 32'h00000123, 1'b0, 32'h00000877, 1'b0, lat, bs, bd);
        total++; if (lat !== 10) begin bad++; $display("FAIL sum_latency got=%0d exp=10", lat); end
        total++; if (result !== 32'h00001000) begin bad++; $display("FAIL sum_result got=%h exp=00001000", result); end
        total++; if ({result_sign, overflow, error} !== 3'b000) begin
            bad++; $display("FAIL sum_flags got=%b%b%b exp=000", result_sign, overflow, error);
        end
        total++; if (bs !== 1'b1 || bd !== 1'b0) begin bad++; $display("FAIL sum_busy got=%b/%b exp=1/0", bs, bd); end
        tick();
        total++; if (done !== 1'b0 || result !== 32'h00001000) begin
            bad++; $display("FAIL sum_done_pulse got=%b/%h exp=0/00001000", done, result);
        end
        // Borrow ripples across three digits.
        launch(3'b000, 32'h00001000, 1'b0, 32'h00000001, 1'b1, lat, bs, bd);
        tick();
        total++; if (result !== 32'h00000999 || result_sign !== 1'b0) begin
            bad++; $display("FAIL sum_borrow_chain got=%h/%b exp=00000999/0", result, result_sign);
        end
    endtask

    task automatic test_sub;
        int lat; bit bs; bit bd;
        launch(3'b001, 32'h00000050, 1'b0, 32'h00000123, 1'b0, lat, bs, bd);
        total++; if (lat !== 10) begin bad++; $display("FAIL sub_latency got=%0d exp=10", lat); end
        total++; if (result !== 32'h00000073 || result_sign !== 1'b1 || overflow !== 1'b0) begin
            bad++; $display("FAIL sub_swap got=%h/%b/%b exp=00000073/1/0", result, result_sign, overflow);
        end
        tick();
        // -250 - (+100) is an effective add of two negatives.
        launch(3'b001, 32'h00000250, 1'b1, 32'h00000100, 1'b0, lat, bs, bd);
        total++; if (result !== 32'h00000350 || result_sign !== 1'b1) begin
            bad++; $display("FAIL sub_neg_add got=%h/%b exp=00000350/1", result, result_sign);
        end
        tick();
        launch(3'b000, 32'h00000001, 1'b0, 32'h99999999, 1'b1, lat, bs, bd);
        total++; if (result !== 32'h99999998 || result_sign !== 1'b1 || overflow !== 1'b0) begin
            bad++; $display("FAIL sub_max got=%h/%b/%b exp=99999998/1/0", result, result_sign, overflow);
        end
        tick();
    endtask

    task automatic test_zero_and_overflow;
        int lat; bit bs; bit bd;
        launch(3'b000, 32'h00000005, 1'b1, 32'h00000005, 1'b0, lat, bs, bd);
        total++; if (result !== 32'h00000000 || result_sign !== 1'b0) begin
            bad++; $display("FAIL no_neg_zero got=%h/%b exp=00000000/0", result, result_sign);
        end
        tick();
        launch(3'b000, 32'h99999999, 1'b0, 32'h00000001, 1'b0, lat, bs, bd);
        total++; if (result !== 32'h00000000 || overflow !== 1'b1 || result_sign !== 1'b0) begin
            bad++; $display("FAIL overflow got=%h/%b/%b exp=00000000/1/0", result, overflow, result_sign);
        end
        tick();
        launch(3'b000, 32'h99999999, 1'b1, 32'h00000002, 1'b1, lat, bs, bd);
        total++; if (result !== 32'h00000001 || overflow !== 1'b1 || result_sign !== 1'b1) begin
            bad++; $display("FAIL overflow_neg got=%h/%b/%b exp=00000001/1/1", result, overflow, result_sign);
        end
        tick();
    endtask

    task automatic test_error;
        int lat; bit bs; bit bd;
        launch(3'b010, 32'h00000012, 1'b0, 32'h00000034, 1'b0, lat, bs, bd);
        total++; if (lat !== 1) begin bad++; $display("FAIL err_latency got=%0d exp=1", lat); end
        total++; if (error !== 1'b1 || result !== 32'h0 || result_sign !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL err_outputs got=%b/%h/%b/%b exp=1/00000000/0/0", error, result, result_sign, overflow);
        end
        total++; if (bs !== 1'b0 || bd !== 1'b0) begin bad++; $display("FAIL err_busy got=%b/%b exp=0/0", bs, bd); end
        tick();
        launch(3'b111, 32'h00000001, 1'b0, 32'h00000001, 1'b0, lat, bs, bd);
        total++; if (error !== 1'b1 || lat !== 1) begin bad++; $display("FAIL err_op7 got=%b/%0d exp=1/1", error, lat); end
        tick();
        launch(3'b000, 32'h00000002, 1'b0, 32'h00000003, 1'b0, lat, bs, bd);
        total++; if (error !== 1'b0 || result !== 32'h00000005) begin
            bad++; $display("FAIL err_clear got=%b/%h exp=0/00000005", error, result);
        end
    endtask

    // start held high through the DONE cycle: ignored there, accepted the cycle after.
    task automatic test_back_to_back;
        int n;
        // Entered in the DONE cycle of the previous operation (result 00000005).
        operation = 3'b000;
        operand0  = 32'h00000040;
        sign0     = 1'b0;
        operand1  = 32'h00000002;
        sign1     = 1'b0;
        start     = 1'b1;
        n = 0;
        tick(); n++;
        tick(); n++;
        start = 1'b0;
        tick(); n++;
        total++; if (result !== 32'h00000005 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_hold got=%h/%b exp=00000005/1", result, busy);
        end
        while (!done && n < 40) begin
            tick();
            n++;
        end
        total++; if (n !== 11 || result !== 32'h00000042) begin
            bad++; $display("FAIL b2b_restart got=%0d/%h exp=11/00000042", n, result);
        end
        tick();
    endtask

    task automatic test_abort;
        int lat; bit bs; bit bd; bit done_seen;
        operation = 3'b000;
        operand0  = 32'h00000123;
        sign0     = 1'b0;
        operand1  = 32'h00000877;
        sign1     = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        // Cycle k+3: extra start with different operands must be ignored.
        operation = 3'b001;
        operand0  = 32'h00000999;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        // Cycle k+5: fourth CALC cycle.
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0 || {result, result_sign, overflow, error} !== 35'd0) begin
            bad++; $display("FAIL abort_outputs got=%b/%b/%h exp=0/0/00000000", busy, done, result);
        end
        done_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done) done_seen = 1'b1;
            tick();
        end
        total++; if (done_seen !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", done_seen); end
        launch(3'b001, 32'h00000050, 1'b0, 32'h00000123, 1'b0, lat, bs, bd);
        total++; if (lat !== 10 || result !== 32'h00000073 || result_sign !== 1'b1) begin
            bad++; $display("FAIL abort_restart got=%0d/%h/%b exp=10/00000073/1", lat, result, result_sign);
        end
        tick();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        start     = 1'b0;
        operation = 3'b000;
        operand0  = 32'h0;
        sign0     = 1'b0;
        operand1  = 32'h0;
        sign1     = 1'b0;
        test_reset();
        test_sum();
        test_sub();
        test_zero_and_overflow();
        test_error();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
